// File: rtl/food_placer.sv
// Food placement for the snake game: pulls random candidates, rejects walls and
// snake cells, falls back to a fixed cell after repeated rejects, and scores eats.
module food_placer #(
   parameter int X_MAX     = 640,
   parameter int Y_MAX     = 480,
   parameter int GRID      = 10,
   parameter int WALL      = 10,
   parameter int MAX_TRIES = 8,
   parameter int FB_X      = 320,
   parameter int FB_Y      = 240,
   parameter int SCORE_W   = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               new_game,
   output logic               rand_req,
   input  logic               rand_valid,
   input  logic [9:0]         pos_x_rand,
   input  logic [9:0]         pos_y_rand,
   output logic [9:0]         chk_x,
   output logic [9:0]         chk_y,
   input  logic               chk_occupied,
   input  logic [9:0]         head_x,
   input  logic [9:0]         head_y,
   input  logic               tick,
   output logic [9:0]         food_x,
   output logic [9:0]         food_y,
   output logic               food_valid,
   output logic               eaten,
   output logic               fallback,
   output logic [SCORE_W-1:0] score
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0] TRIES_LAST = TRY_W'(MAX_TRIES - 1);
   localparam logic [9:0] X_MAX_C = 10'(X_MAX);
   localparam logic [9:0] Y_MAX_C = 10'(Y_MAX);
   localparam logic [9:0] GRID_C  = 10'(GRID);
   localparam logic [9:0] WALL_C  = 10'(WALL);
   localparam logic [9:0] X_HI_C  = 10'(X_MAX - WALL);
   localparam logic [9:0] Y_HI_C  = 10'(Y_MAX - WALL);
   localparam logic [9:0] FB_X_C  = 10'(FB_X);
   localparam logic [9:0] FB_Y_C  = 10'(FB_Y);

   typedef enum logic [1:0] {S_REQ, S_WALL, S_BODY, S_PLACED} state_t;

   state_t             state_reg, state_next;
   logic [9:0]         cand_x_reg, cand_x_next, cand_y_reg, cand_y_next;
   logic [9:0]         chk_x_reg, chk_x_next, chk_y_reg, chk_y_next;
   logic [9:0]         food_x_reg, food_x_next, food_y_reg, food_y_next;
   logic               food_valid_reg, food_valid_next;
   logic               eaten_reg, eaten_next, fallback_reg, fallback_next;
   logic [TRY_W-1:0]   tries_reg, tries_next;
   logic [SCORE_W-1:0] score_reg, score_next;
   logic               is_wall, reject;

   // Single wrap then snap down to the grid; inputs never exceed twice the extent.
   function automatic logic [9:0] snap(input logic [9:0] v, input logic [9:0] lim);
      logic [9:0] m;
      m = (v >= lim) ? v - lim : v;
      return m - (m % GRID_C);
   endfunction

   assign is_wall = (cand_x_reg < WALL_C) || (cand_x_reg >= X_HI_C) ||
                    (cand_y_reg < WALL_C) || (cand_y_reg >= Y_HI_C);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= S_REQ;
         cand_x_reg     <= '0;
         cand_y_reg     <= '0;
         chk_x_reg      <= '0;
         chk_y_reg      <= '0;
         food_x_reg     <= '0;
         food_y_reg     <= '0;
         food_valid_reg <= 1'b0;
         eaten_reg      <= 1'b0;
         fallback_reg   <= 1'b0;
         tries_reg      <= '0;
         score_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         cand_x_reg     <= cand_x_next;
         cand_y_reg     <= cand_y_next;
         chk_x_reg      <= chk_x_next;
         chk_y_reg      <= chk_y_next;
         food_x_reg     <= food_x_next;
         food_y_reg     <= food_y_next;
         food_valid_reg <= food_valid_next;
         eaten_reg      <= eaten_next;
         fallback_reg   <= fallback_next;
         tries_reg      <= tries_next;
         score_reg      <= score_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cand_x_next     = cand_x_reg;
      cand_y_next     = cand_y_reg;
      chk_x_next      = chk_x_reg;
      chk_y_next      = chk_y_reg;
      food_x_next     = food_x_reg;
      food_y_next     = food_y_reg;
      food_valid_next = food_valid_reg;
      eaten_next      = 1'b0;
      fallback_next   = 1'b0;
      tries_next      = tries_reg;
      score_next      = score_reg;
      reject          = 1'b0;

      if (new_game) begin
         state_next      = S_REQ;
         cand_x_next     = '0;
         cand_y_next     = '0;
         chk_x_next      = '0;
         chk_y_next      = '0;
         food_x_next     = '0;
         food_y_next     = '0;
         food_valid_next = 1'b0;
         tries_next      = '0;
         score_next      = '0;
      end else begin
         case (state_reg)
            S_REQ: begin
               if (rand_valid) begin
                  cand_x_next = snap(pos_x_rand, X_MAX_C);
                  cand_y_next = snap(pos_y_rand, Y_MAX_C);
                  state_next  = S_WALL;
               end
            end
            S_WALL: begin
               if (is_wall) begin
                  reject = 1'b1;
               end else begin
                  chk_x_next = cand_x_reg;
                  chk_y_next = cand_y_reg;
                  state_next = S_BODY;
               end
            end
            S_BODY: begin
               if (chk_occupied || (cand_x_reg == head_x && cand_y_reg == head_y)) begin
                  reject = 1'b1;
               end else begin
                  food_x_next     = cand_x_reg;
                  food_y_next     = cand_y_reg;
                  food_valid_next = 1'b1;
                  tries_next      = '0;
                  state_next      = S_PLACED;
               end
            end
            S_PLACED: begin
               if (tick && head_x == food_x_reg && head_y == food_y_reg) begin
                  eaten_next      = 1'b1;
                  score_next      = (score_reg == '1) ? score_reg : score_reg + 1'b1;
                  food_valid_next = 1'b0;
                  state_next      = S_REQ;
               end
            end
            default: state_next = S_REQ;
         endcase

         // The last allowed reject places the fallback cell instead of asking again.
         if (reject) begin
            if (tries_reg == TRIES_LAST) begin
               food_x_next     = FB_X_C;
               food_y_next     = FB_Y_C;
               food_valid_next = 1'b1;
               fallback_next   = 1'b1;
               tries_next      = '0;
               state_next      = S_PLACED;
            end else begin
               tries_next = tries_reg + 1'b1;
               state_next = S_REQ;
            end
         end
      end
   end

   assign rand_req   = (state_reg == S_REQ);
   assign chk_x      = chk_x_reg;
   assign chk_y      = chk_y_reg;
   assign food_x     = food_x_reg;
   assign food_y     = food_y_reg;
   assign food_valid = food_valid_reg;
   assign eaten      = eaten_reg;
   assign fallback   = fallback_reg;
   assign score      = score_reg;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: stimulus queues expected placements and eats,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_food_placer;

   logic       clock = 1'b0;
   logic       reset_n, new_game, rand_valid, tick;
   logic [9:0] pos_x_rand, pos_y_rand, head_x, head_y;
   logic [9:0] chk_x, chk_y, food_x, food_y;
   logic       chk_occupied, rand_req, food_valid, eaten, fallback;
   logic [7:0] score;

   logic       occ_en;
   logic [9:0] occ_x, occ_y;

   typedef struct {
      int kind;   // 0 = placement, 1 = eat
      int x;
      int y;
      int fb;
      int sc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   logic prev_fv = 1'b0;
   int   exp_score, cur_fx, cur_fy;

   always #5 clock = ~clock;

   // Body occupancy model: a single occupied cell, answered from the registered address.
   assign chk_occupied = occ_en && (chk_x == occ_x) && (chk_y == occ_y);

   food_placer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .new_game     (new_game),
      .rand_req     (rand_req),
      .rand_valid   (rand_valid),
      .pos_x_rand   (pos_x_rand),
      .pos_y_rand   (pos_y_rand),
      .chk_x        (chk_x),
      .chk_y        (chk_y),
      .chk_occupied (chk_occupied),
      .head_x       (head_x),
      .head_y       (head_y),
      .tick         (tick),
      .food_x       (food_x),
      .food_y       (food_y),
      .food_valid   (food_valid),
      .eaten        (eaten),
      .fallback     (fallback),
      .score        (score)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push_place(input int x, input int y, input int fb);
      exp_t e;
      e.kind = 0; e.x = x; e.y = y; e.fb = fb; e.sc = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_eat(input int sc);
      exp_t e;
      e.kind = 1; e.x = 0; e.y = 0; e.fb = 0; e.sc = sc;
      exp_q.push_back(e);
   endtask

   task automatic send(input int x, input int y);
      int n = 0;
      while (!rand_req && n < 20) begin
         cyc();
         n++;
      end
      chk("req_wait", int'(rand_req), 1);
      pos_x_rand = 10'(x);
      pos_y_rand = 10'(y);
      rand_valid = 1'b1;
      cyc();
      rand_valid = 1'b0;
   endtask

   task automatic wait_fv();
      int n = 0;
      while (!food_valid && n < 10) begin
         cyc();
         n++;
      end
      chk("place_wait", int'(food_valid), 1);
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      cyc();
      new_game = 1'b0;
   endtask

   always @(negedge clock) begin
      if (food_valid && !prev_fv) begin
         $display("event place food=(%0d,%0d) fallback=%0d", food_x, food_y, fallback);
         if (exp_q.size() == 0) begin
            chk("place_unexpected", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("place_kind", 0, mon_e.kind);
            chk("place_x", int'(food_x), mon_e.x);
            chk("place_y", int'(food_y), mon_e.y);
            chk("place_fb", int'(fallback), mon_e.fb);
         end
      end else if (fallback) begin
         chk("fallback_stray", 1, 0);
      end
      if (eaten) begin
         $display("event eat score=%0d", score);
         if (exp_q.size() == 0) begin
            chk("eat_unexpected", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("eat_kind", 1, mon_e.kind);
            chk("eat_score", int'(score), mon_e.sc);
         end
      end
      prev_fv = food_valid;
   end

   initial begin
      reset_n = 1'b0; new_game = 1'b0; rand_valid = 1'b0; tick = 1'b0;
      pos_x_rand = '0; pos_y_rand = '0; head_x = '0; head_y = '0;
      occ_en = 1'b0; occ_x = '0; occ_y = '0;
      cyc();
      cyc();
      chk("rst_req", int'(rand_req), 1);
      chk("rst_fv", int'(food_valid), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_food_x", int'(food_x), 0);
      reset_n = 1'b1;
      cyc();

      // T1: asynchronous reset while in BODY
      send(123, 77);
      cyc();
      chk("t1_chk_x_body", int'(chk_x), 120);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_chk_x", int'(chk_x), 0);
      chk("t1_chk_y", int'(chk_y), 0);
      chk("t1_req", int'(rand_req), 1);
      chk("t1_fv", int'(food_valid), 0);
      cyc();
      reset_n = 1'b1;
      cyc();
      chk("t1_req_after", int'(rand_req), 1);

      // T2: accepted placement with 3-cycle latency
      push_place(120, 70, 0);
      send(123, 77);
      chk("t2_lat0", int'(food_valid), 0);
      cyc();
      chk("t2_lat1", int'(food_valid), 0);
      cyc();
      chk("t2_lat2", int'(food_valid), 1);
      chk("t2_req", int'(rand_req), 0);
      pulse_new_game();
      chk("t2_ng_fv", int'(food_valid), 0);
      chk("t2_ng_fx", int'(food_x), 0);

      // Wrap boundary: 1000 -> 360
      push_place(360, 200, 0);
      send(1000, 200);
      wait_fv();
      pulse_new_game();

      // 639/479 snaps onto the far wall
      send(639, 479);
      cyc();
      chk("edge_req", int'(rand_req), 1);
      chk("edge_fv", int'(food_valid), 0);

      // T3: wall reject, body reject, then accept
      occ_en = 1'b1; occ_x = 10'd200; occ_y = 10'd200;
      send(5, 200);
      cyc();
      chk("t3_wall_req", int'(rand_req), 1);
      send(200, 200);
      cyc();
      chk("t3_chk_x", int'(chk_x), 200);
      cyc();
      chk("t3_body_req", int'(rand_req), 1);
      chk("t3_body_fv", int'(food_valid), 0);
      push_place(300, 100, 0);
      send(300, 100);
      wait_fv();

      // T5: miss tick, then eat
      head_x = 10'd310; head_y = 10'd100; tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("t5_miss_fv", int'(food_valid), 1);
      chk("t5_miss_eat", int'(eaten), 0);
      head_x = 10'd300; tick = 1'b1;
      push_eat(1);
      cyc();
      tick = 1'b0;
      chk("t5_eaten", int'(eaten), 1);
      chk("t5_fv", int'(food_valid), 0);
      chk("t5_req", int'(rand_req), 1);
      cyc();
      chk("t5_eaten_pulse", int'(eaten), 0);
      exp_score = 1;

      // T4: MAX_TRIES wall candidates -> fallback
      head_x = '0; head_y = '0;
      push_place(320, 240, 1);
      for (int i = 0; i < 8; i++) begin
         send(5, 5);
         cyc();
         if (i < 7) chk("t4_req", int'(rand_req), 1);
      end
      chk("t4_no_9th_req", int'(rand_req), 0);
      chk("t4_fallback", int'(fallback), 1);
      cur_fx = 320; cur_fy = 240;

      // T6: run score up to saturation
      for (int i = 0; i < 256; i++) begin
         head_x = 10'(cur_fx); head_y = 10'(cur_fy); tick = 1'b1;
         exp_score = (exp_score == 255) ? 255 : exp_score + 1;
         push_eat(exp_score);
         cyc();
         tick = 1'b0;
         head_x = '0; head_y = '0;
         push_place(300, 100, 0);
         send(300, 100);
         wait_fv();
         cur_fx = 300; cur_fy = 100;
      end
      chk("t6_sat", int'(score), 255);

      // new_game wins over a matching tick
      head_x = 10'd300; head_y = 10'd100; tick = 1'b1; new_game = 1'b1;
      cyc();
      tick = 1'b0; new_game = 1'b0;
      chk("t6_ng_score", int'(score), 0);
      chk("t6_ng_eaten", int'(eaten), 0);
      chk("t6_ng_fv", int'(food_valid), 0);
      chk("t6_ng_req", int'(rand_req), 1);
      cyc();
      cyc();
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
